imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a 2-entry (output + skid) valid/ready pipeline.
// Latency: 1 cycle from accepted instruction to oValid when the output register is free or draining.
// Backpressure: oReady is registered "skid empty"; it falls one cycle after a stalled accept fills the skid.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid,
  output logic             oReady,
  input  logic [31:0]      iInstrucao,
  input  logic [TAG_W-1:0] iTag,
  output logic             oValid,
  input  logic             iReady,
  output logic [XLEN-1:0]  oImm,
  output logic [2:0]       oFmt,
  output logic             oIllegal,
  output logic [TAG_W-1:0] oTag
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ZIMM  = 3'd7;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   rdy_q;
  entry_t dec;
  logic   xfer_in;
  logic   xfer_out;

  logic [31:0] v32;
  logic [2:0]  f3;

  // Decode the incoming word into a 32-bit immediate, then sign-extend from bit 31 to XLEN.
  // Zero-extended formats leave bit 31 clear, so the same extension serves them.
  always_comb begin
    v32     = 32'd0;
    dec.fmt = FMT_NONE;
    dec.ill = 1'b0;
    dec.tag = iTag;
    f3      = iInstrucao[14:12];
    if (iInstrucao[1:0] != 2'b11) begin
      dec.ill = 1'b1;
    end else begin
      case (iInstrucao[6:0])
        OPC_LOAD, OPC_JALR, OPC_FENCE: begin
          dec.fmt = FMT_I;
          v32     = {{20{iInstrucao[31]}}, iInstrucao[31:20]};
        end
        OPC_OP_IMM: begin
          if (f3 == 3'b001 || f3 == 3'b101) begin
            dec.fmt = FMT_SHAMT;
            v32     = (XLEN == 64) ? {26'd0, iInstrucao[25:20]} : {27'd0, iInstrucao[24:20]};
          end else begin
            dec.fmt = FMT_I;
            v32     = {{20{iInstrucao[31]}}, iInstrucao[31:20]};
          end
        end
        OPC_OP_IMM32: begin
          if (XLEN != 64) begin
            dec.ill = 1'b1;
          end else if (f3 == 3'b001 || f3 == 3'b101) begin
            dec.fmt = FMT_SHAMT;
            v32     = {27'd0, iInstrucao[24:20]};
          end else begin
            dec.fmt = FMT_I;
            v32     = {{20{iInstrucao[31]}}, iInstrucao[31:20]};
          end
        end
        OPC_STORE: begin
          dec.fmt = FMT_S;
          v32     = {{20{iInstrucao[31]}}, iInstrucao[31:25], iInstrucao[11:7]};
        end
        OPC_BRANCH: begin
          dec.fmt = FMT_B;
          v32     = {{19{iInstrucao[31]}}, iInstrucao[31], iInstrucao[7],
                     iInstrucao[30:25], iInstrucao[11:8], 1'b0};
        end
        OPC_LUI, OPC_AUIPC: begin
          dec.fmt = FMT_U;
          v32     = {iInstrucao[31:12], 12'd0};
        end
        OPC_JAL: begin
          dec.fmt = FMT_J;
          v32     = {{11{iInstrucao[31]}}, iInstrucao[31], iInstrucao[19:12],
                     iInstrucao[20], iInstrucao[30:21], 1'b0};
        end
        OPC_SYSTEM: begin
          if (f3[2]) begin
            dec.fmt = FMT_ZIMM;
            v32     = {27'd0, iInstrucao[19:15]};
          end else begin
            dec.fmt = FMT_I;
            v32     = {{20{iInstrucao[31]}}, iInstrucao[31:20]};
          end
        end
        OPC_OP: begin
          dec.fmt = FMT_NONE;
        end
        default: begin
          dec.ill = 1'b1;
        end
      endcase
    end
    dec.imm = XLEN'({{32{v32[31]}}, v32});
  end

  assign xfer_in  = iValid && oReady;
  assign xfer_out = oValid && iReady;

  // Occupancy FSM: route accepted entries into the output register or the skid, and refill from the skid.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (xfer_in) begin
          out_d   = dec;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (xfer_in && xfer_out) begin
          out_d = dec;
        end else if (xfer_in) begin
          skid_d  = dec;
          state_d = ST_FULL;
        end else if (xfer_out) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer_out) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State and data registers; reset clears both entries so outputs read 0, never X.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != ST_FULL);
    end
  end

  // rdy_q is the registered skid-empty flag; it is masked while reset is held so nothing is taken then.
  assign oReady   = rdy_q && !iRST;
  assign oValid   = (state_q != ST_EMPTY);
  assign oImm     = out_q.imm;
  assign oFmt     = out_q.fmt;
  assign oIllegal = out_q.ill;
  assign oTag     = out_q.tag;

endmodule
